imem_ctrl: RTL and testbench

Sequencing controller for the byte-addressable instruction memory. It shares a single byte-wide memory port between two requesters: the CPU fetch path, which reads 32-bit instructions, and the program loader, which writes bytes. Each fetch is assembled from four byte reads at a, a+1, a+2 and a+3. The block sits between the fetch stage/loader and the instruction memory array.

---
 rtl/imem_ctrl_pkg.sv | 31 +++
 rtl/imem_rr_arb.sv | 35 +++
 rtl/imem_ctrl.sv | 134 +++++++++++++
 tb/tb_imem_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared types and helpers for the instruction memory sequencing controller.
// Byte order of assembled fetches is selected by IMEM_LITTLE_ENDIAN_EN.
package imem_ctrl_pkg;

   localparam int unsigned BEATS  = 4;
   localparam int unsigned BEAT_W = 2;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StRdTail,
      StRdDone,
      StWr,
      StWrDone
   } state_e;

   typedef enum logic {
      FETCH,
      LOAD
   } grant_e;

   // Byte lane of fetch_instr that receives the byte read on a given beat.
   function automatic logic [BEAT_W-1:0] byte_lane(input logic [BEAT_W-1:0] beat);
`ifdef IMEM_LITTLE_ENDIAN_EN
      return beat;
`else
      return 2'd3 - beat;
`endif
   endfunction

endpackage

// File: rtl/imem_rr_arb.sv
// Two-way round-robin arbiter between the fetch path and the program loader.
// last_grant only moves when the controller actually takes a grant in IDLE.
module imem_rr_arb
   import imem_ctrl_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   fetch_req,
   input  logic   ld_req,
   input  logic   idle,
   output logic   grant_valid,
   output grant_e grant
);

   grant_e last_grant_q;

   always_comb begin
      grant_valid = fetch_req | ld_req;
      grant       = FETCH;
      if (fetch_req && ld_req) begin
         grant = (last_grant_q == FETCH) ? LOAD : FETCH;
      end else if (ld_req) begin
         grant = LOAD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= FETCH;
      end else if (idle && grant_valid) begin
         last_grant_q <= grant;
      end
   end

endmodule

// File: rtl/imem_ctrl.sv
// Shares one byte-wide memory port between 4-beat instruction fetches and loader byte writes.
// Fetch byte order: big-endian by default, RISC-V order with IMEM_LITTLE_ENDIAN_EN defined.
module imem_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ack,
   output logic [31:0]       fetch_instr,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_byte,
   output logic              ld_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   state_e              state_q;
   logic [BEAT_W-1:0]   beat_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [7:0]          wdata_q;
   logic [31:0]         buf_q;
   logic [31:0]         instr_q;
   logic [31:0]         tail_word;
   logic                fetch_ack_q;
   logic                ld_ack_q;
   logic                idle;
   logic                grant_valid;
   grant_e              grant;

   assign idle = (state_q == StIdle);

   imem_rr_arb u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_req   (fetch_req),
      .ld_req      (ld_req),
      .idle        (idle),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // Beat 3 arrives during RD_TAIL; merge it straight into the word handed to fetch_instr.
   always_comb begin
      tail_word = buf_q;
      tail_word[{byte_lane(2'd3), 3'b000} +: 8] = mem_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         beat_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         buf_q       <= '0;
         instr_q     <= '0;
         fetch_ack_q <= 1'b0;
         ld_ack_q    <= 1'b0;
      end else begin
         fetch_ack_q <= 1'b0;
         ld_ack_q    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (grant_valid) begin
                  beat_q <= '0;
                  if (grant == LOAD) begin
                     addr_q  <= ld_addr;
                     wdata_q <= ld_byte;
                     state_q <= StWr;
                  end else begin
                     addr_q  <= fetch_addr;
                     state_q <= StRd;
                  end
               end
            end
            StRd: begin
               // Read data lags the address by one cycle, so beat k lands during beat k+1.
               if (beat_q != '0) begin
                  buf_q[{byte_lane(beat_q - 2'd1), 3'b000} +: 8] <= mem_rdata;
               end
               beat_q <= beat_q + 2'd1;
               if (beat_q == 2'(BEATS - 1)) begin
                  state_q <= StRdTail;
               end
            end
            StRdTail: begin
               instr_q     <= tail_word;
               fetch_ack_q <= 1'b1;
               state_q     <= StRdDone;
            end
            StRdDone: begin
               state_q <= StIdle;
            end
            StWr: begin
               ld_ack_q <= 1'b1;
               state_q  <= StWrDone;
            end
            StWrDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Memory port decoded from state and beat only, never from the request inputs.
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (state_q == StRd) begin
         mem_addr = addr_q + ADDR_W'(beat_q);
      end else if (state_q == StWr) begin
         mem_addr  = addr_q;
         mem_we    = 1'b1;
         mem_wdata = wdata_q;
      end
   end

   assign fetch_ack   = fetch_ack_q;
   assign ld_ack      = ld_ack_q;
   assign fetch_instr = instr_q;
   assign busy        = !idle;

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with a 256-byte memory model (low address bits only).
module tb_imem_ctrl;

   logic        clk;
   logic        rst_n;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ack;
   logic [31:0] fetch_instr;
   logic        ld_req;
   logic [31:0] ld_addr;
   logic [7:0]  ld_byte;
   logic        ld_ack;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        busy;

   int vectors;
   int errors;

   logic [7:0] mem [0:255];

`ifdef IMEM_LITTLE_ENDIAN_EN
   localparam logic [31:0] ExpInstr10 = 32'h0050_0513;
   localparam logic [31:0] ExpInstr20 = 32'h0000_00AB;
`else
   localparam logic [31:0] ExpInstr10 = 32'h1305_5000;
   localparam logic [31:0] ExpInstr20 = 32'hAB00_0000;
`endif

   imem_ctrl #(.ADDR_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_ack   (fetch_ack),
      .fetch_instr (fetch_instr),
      .ld_req      (ld_req),
      .ld_addr     (ld_addr),
      .ld_byte     (ld_byte),
      .ld_ack      (ld_ack),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: 1-cycle read latency, preloaded on reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[8'h10] <= 8'h13;
         mem[8'h11] <= 8'h05;
         mem[8'h12] <= 8'h50;
         mem[8'h13] <= 8'h00;
         mem_rdata  <= 8'h00;
      end else begin
         mem_rdata <= mem[mem_addr[7:0]];
         if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " fetch_ack"}, 32'(fetch_ack), 32'h0);
      chk({tag, " ld_ack"}, 32'(ld_ack), 32'h0);
      chk({tag, " mem_addr"}, mem_addr, 32'h0);
      chk({tag, " mem_we"}, 32'(mem_we), 32'h0);
      chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'h0);
      chk({tag, " busy"}, 32'(busy), 32'h0);
   endtask

   // Called in cycle 0 (IDLE); returns in cycle 6 with fetch_ack expected high.
   task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, input string tag,
                           input bit hold);
      fetch_req  = 1'b1;
      fetch_addr = a;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k == 1) fetch_addr = ~a;
         chk({tag, " mem_addr"}, mem_addr, a + 32'(k - 1));
         chk({tag, " mem_we"}, 32'(mem_we), 32'h0);
      end
      step();
      chk({tag, " ack early"}, 32'(fetch_ack), 32'h0);
      step();
      chk({tag, " ack"}, 32'(fetch_ack), 32'h1);
      chk({tag, " instr"}, fetch_instr, exp);
      if (!hold) fetch_req = 1'b0;
   endtask

   initial begin
      vectors    = 0;
      errors     = 0;
      rst_n      = 1'b0;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      ld_req     = 1'b0;
      ld_addr    = '0;
      ld_byte    = '0;
      #1;
      chk_idle_outputs("reset");
      chk("reset instr", fetch_instr, 32'h0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Plain fetch, request dropped in cycle 2.
      fetch_req  = 1'b1;
      fetch_addr = 32'h10;
      chk("f0 busy", 32'(busy), 32'h0);
      step();
      chk("f1 mem_addr", mem_addr, 32'h10);
      chk("f1 busy", 32'(busy), 32'h1);
      step();
      fetch_req = 1'b0;
      chk("f2 mem_addr", mem_addr, 32'h11);
      step();
      chk("f3 mem_addr", mem_addr, 32'h12);
      step();
      chk("f4 mem_addr", mem_addr, 32'h13);
      step();
      chk("f5 ack", 32'(fetch_ack), 32'h0);
      step();
      chk("f6 ack", 32'(fetch_ack), 32'h1);
      chk("f6 instr", fetch_instr, ExpInstr10);
      step();
      chk("f7 ack", 32'(fetch_ack), 32'h0);
      chk("f7 busy", 32'(busy), 32'h0);
      chk("f7 instr hold", fetch_instr, ExpInstr10);

      // Tie from reset: loader first, then fetch.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      fetch_req  = 1'b1;
      fetch_addr = 32'h10;
      ld_req     = 1'b1;
      ld_addr    = 32'h20;
      ld_byte    = 8'hAB;
      step();
      ld_addr = 32'h30;
      ld_byte = 8'h55;
      chk("t1 mem_we", 32'(mem_we), 32'h1);
      chk("t1 mem_addr", mem_addr, 32'h20);
      chk("t1 mem_wdata", 32'(mem_wdata), 32'hAB);
      step();
      chk("t2 ld_ack", 32'(ld_ack), 32'h1);
      chk("t2 mem_we", 32'(mem_we), 32'h0);
      ld_req = 1'b0;
      step();
      chk("t3 busy", 32'(busy), 32'h0);
      chk("t3 ld_ack", 32'(ld_ack), 32'h0);
      step();
      chk("t4 mem_addr", mem_addr, 32'h10);
      for (int c = 5; c <= 8; c++) step();
      chk("t8 ack", 32'(fetch_ack), 32'h0);
      step();
      chk("t9 ack", 32'(fetch_ack), 32'h1);
      chk("t9 instr", fetch_instr, ExpInstr10);
      fetch_req = 1'b0;
      step();

      // Read back the loaded byte.
      do_fetch(32'h20, ExpInstr20, "rb", 1'b0);
      step();

      // Address wrap.
      do_fetch(32'hFFFF_FFFE, 32'h0, "wrap", 1'b0);
      step();

      // Reset during beat 2.
      fetch_req  = 1'b1;
      fetch_addr = 32'h10;
      step();
      step();
      step();
      chk("rst beat2 mem_addr", mem_addr, 32'h12);
      fetch_req = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk_idle_outputs("rst async");
      chk("rst async instr", fetch_instr, 32'h0);
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         chk("rst no ack", 32'(fetch_ack), 32'h0);
      end
      do_fetch(32'h10, ExpInstr10, "post rst", 1'b0);
      step();

      // Request held after ack is a new fetch.
      do_fetch(32'h10, ExpInstr10, "b2b a", 1'b1);
      fetch_addr = 32'h11;
      step();
      chk("b2b idle busy", 32'(busy), 32'h0);
      step();
      chk("b2b again mem_addr", mem_addr, 32'h11);
      chk("b2b again busy", 32'(busy), 32'h1);
      fetch_req = 1'b0;
      for (int c = 2; c <= 6; c++) step();
      chk("b2b again ack", 32'(fetch_ack), 32'h1);
      chk("b2b again instr", fetch_instr,
`ifdef IMEM_LITTLE_ENDIAN_EN
          32'h0000_5005
`else
          32'h0550_0000
`endif
      );
      step();
      chk("b2b end busy", 32'(busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
